// File: rtl/hazard_unit_pkg.sv
// Shared constants for the pipeline hazard unit: FSM state encodings and
// the register index that never carries a real dependency (x0 / NOP).
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    localparam logic [4:0] REG_X0     = 5'd0;
    localparam int         WAIT_CNT_W = 8;

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle. The pipeline side (master) supplies
// register/branch/memory status; the hazard unit (slave) returns the stage
// enables, flushes, error flag, stall counter and FSM state.
interface hazard_unit_if #(
    parameter int STALL_CNT_W = 16
);
    logic [4:0]             EX_MEM_RD;
    logic                   EX_MEM_WRITE;
    logic [4:0]             ID_EX_RS1;
    logic [4:0]             ID_EX_RS2;
    logic                   ID_EX_USE1;
    logic                   ID_EX_USE2;
    logic                   BRANCH_TAKEN;
    logic                   MEM_REQ;
    logic                   MEM_READY;

    logic                   PC_EN;
    logic                   IF_ID_EN;
    logic                   ID_EX_EN;
    logic                   EX_MEM_EN;
    logic                   MEM_WB_EN;
    logic                   IF_ID_FLUSH;
    logic                   ID_EX_FLUSH;
    logic                   EX_MEM_BUBBLE;
    logic                   MEM_ERR;
    logic [STALL_CNT_W-1:0] STALL_CNT;
    logic [1:0]             STATE;

    modport master (
        output EX_MEM_RD, EX_MEM_WRITE, ID_EX_RS1, ID_EX_RS2, ID_EX_USE1,
               ID_EX_USE2, BRANCH_TAKEN, MEM_REQ, MEM_READY,
        input  PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN, IF_ID_FLUSH,
               ID_EX_FLUSH, EX_MEM_BUBBLE, MEM_ERR, STALL_CNT, STATE
    );

    modport slave (
        input  EX_MEM_RD, EX_MEM_WRITE, ID_EX_RS1, ID_EX_RS2, ID_EX_USE1,
               ID_EX_USE2, BRANCH_TAKEN, MEM_REQ, MEM_READY,
        output PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN, IF_ID_FLUSH,
               ID_EX_FLUSH, EX_MEM_BUBBLE, MEM_ERR, STALL_CNT, STATE
    );

endinterface

// File: rtl/raw_detect.sv
// RAW comparator: the EX/MEM producer's destination matches a source that the
// ID/EX consumer actually reads. Writes to x0 never create a dependency.
module raw_detect
    import hazard_unit_pkg::*;
(
    input  logic [4:0] i_rd,
    input  logic       i_write,
    input  logic [4:0] i_rs1,
    input  logic       i_use1,
    input  logic [4:0] i_rs2,
    input  logic       i_use2,
    output logic       o_raw
);

    logic w_hit1;
    logic w_hit2;

    assign w_hit1 = (i_rd == i_rs1) && i_use1;
    assign w_hit2 = (i_rd == i_rs2) && i_use2;
    assign o_raw  = i_write && (i_rd != REG_X0) && (w_hit1 || w_hit2);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: one-cycle RAW stall against EX/MEM, branch flush,
// memory-wait freeze with timeout to a sticky error state, and a saturating
// stall-cycle counter.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int STALL_CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave bus
);

    state_t                  r_state;
    logic [WAIT_CNT_W-1:0]   r_wait_cnt;
    logic                    r_mem_err;
    logic [STALL_CNT_W-1:0]  r_stall_cnt;

    logic w_raw;
    logic w_mem_busy;
    logic w_freeze;
    logic w_timeout;
    logic w_pc_en;
    logic w_if_id_en;
    logic w_id_ex_en;
    logic w_ex_mem_en;
    logic w_mem_wb_en;
    logic w_if_id_flush;
    logic w_id_ex_flush;
    logic w_ex_mem_bubble;

    raw_detect u_raw (
        .i_rd    (bus.EX_MEM_RD),
        .i_write (bus.EX_MEM_WRITE),
        .i_rs1   (bus.ID_EX_RS1),
        .i_use1  (bus.ID_EX_USE1),
        .i_rs2   (bus.ID_EX_RS2),
        .i_use2  (bus.ID_EX_USE2),
        .o_raw   (w_raw)
    );

    // A pending access that has not completed this cycle freezes the whole
    // pipe; the error state freezes it permanently until reset.
    assign w_mem_busy = bus.MEM_REQ && !bus.MEM_READY;
    assign w_freeze   = w_mem_busy || (r_state == ST_ERR);
    // Timeouts above the counter range simply never fire.
    assign w_timeout  = (int'(r_wait_cnt) == MEM_TIMEOUT);

    // Output priority: reset, freeze, RAW stall, taken branch, normal flow.
    // A branch seen during a stall or freeze is dropped: its operands are
    // stale, and EX re-resolves it once the pipe moves again.
    always_comb begin
        w_pc_en         = 1'b1;
        w_if_id_en      = 1'b1;
        w_id_ex_en      = 1'b1;
        w_ex_mem_en     = 1'b1;
        w_mem_wb_en     = 1'b1;
        w_if_id_flush   = 1'b0;
        w_id_ex_flush   = 1'b0;
        w_ex_mem_bubble = 1'b0;
        if (rst) begin
            w_if_id_flush   = 1'b1;
            w_id_ex_flush   = 1'b1;
            w_ex_mem_bubble = 1'b1;
        end else if (w_freeze) begin
            w_pc_en     = 1'b0;
            w_if_id_en  = 1'b0;
            w_id_ex_en  = 1'b0;
            w_ex_mem_en = 1'b0;
            w_mem_wb_en = 1'b0;
        end else if (w_raw) begin
            // Hold front end, let the producer drain to MEM/WB and insert a
            // NOP behind it so forwarding from MEM/WB covers the consumer.
            w_pc_en         = 1'b0;
            w_if_id_en      = 1'b0;
            w_id_ex_en      = 1'b0;
            w_ex_mem_bubble = 1'b1;
        end else if (bus.BRANCH_TAKEN) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
        end
    end

    // Memory-wait FSM with wait counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_wait_cnt <= '0;
                    if (w_mem_busy) r_state <= ST_MEM_WAIT;
                end
                ST_MEM_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    // Completion wins over a simultaneous timeout.
                    if (bus.MEM_READY) begin
                        r_state <= ST_RUN;
                    end else if (w_timeout) begin
                        r_state   <= ST_ERR;
                        r_mem_err <= 1'b1;
                    end
                end
                ST_ERR: begin
                    r_mem_err <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // Saturating count of cycles where the PC did not advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (!w_pc_en && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.PC_EN         = w_pc_en;
    assign bus.IF_ID_EN      = w_if_id_en;
    assign bus.ID_EX_EN      = w_id_ex_en;
    assign bus.EX_MEM_EN     = w_ex_mem_en;
    assign bus.MEM_WB_EN     = w_mem_wb_en;
    assign bus.IF_ID_FLUSH   = w_if_id_flush;
    assign bus.ID_EX_FLUSH   = w_id_ex_flush;
    assign bus.EX_MEM_BUBBLE = w_ex_mem_bubble;
    assign bus.MEM_ERR       = r_mem_err;
    assign bus.STALL_CNT     = r_stall_cnt;
    assign bus.STATE         = r_state;

endmodule
